// File: rtl/scoreboard_status_table.sv
// Scoreboard status table: per-FU instruction records, RAW/WAR tracking and
// single read-operand / write-back grants for the issue stage.
module scoreboard_status_table #(
   parameter int NUM_FUS  = 4,
   parameter int NUM_REGS = 32,
   parameter int REG_BITS = 5,
   parameter int FU_BITS  = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        issue_valid,
   input  logic [FU_BITS-1:0]          issue_fu,
   input  logic [REG_BITS-1:0]         issue_fi,
   input  logic [REG_BITS-1:0]         issue_fj,
   input  logic [REG_BITS-1:0]         issue_fk,
   input  logic [NUM_FUS-1:0]          ex_done,
   output logic [NUM_FUS-1:0]          fu_busy,
   output logic [NUM_REGS*NUM_FUS-1:0] reg_result_fu,
   output logic                        rd_valid,
   output logic [FU_BITS-1:0]          rd_fu,
   output logic [REG_BITS-1:0]         rd_fj,
   output logic [REG_BITS-1:0]         rd_fk,
   output logic                        wb_valid,
   output logic [FU_BITS-1:0]          wb_fu,
   output logic [REG_BITS-1:0]         wb_fi,
   output logic                        issue_err
);

   localparam int RR_W     = NUM_REGS * NUM_FUS;
   localparam int RR_IDX_W = $clog2(RR_W);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUED  = 2'd1,
      ST_EXEC    = 2'd2,
      ST_WB_WAIT = 2'd3
   } fu_state_t;

   fu_state_t            state_r [NUM_FUS];
   logic [REG_BITS-1:0]  fi_r    [NUM_FUS];
   logic [REG_BITS-1:0]  fj_r    [NUM_FUS];
   logic [REG_BITS-1:0]  fk_r    [NUM_FUS];
   logic [FU_BITS-1:0]   qj_r    [NUM_FUS];
   logic [FU_BITS-1:0]   qk_r    [NUM_FUS];
   logic [NUM_FUS-1:0]   qjv_r, qkv_r, rj_r, rk_r;
   logic [RR_W-1:0]      reg_result_r;
   logic                 issue_err_r;

   logic [NUM_FUS-1:0]   rd_elig_s, wb_elig_s, war_s, wb_clr_s, row_j_s, row_k_s, issue_onehot_s;
   logic [FU_BITS-1:0]   rd_idx_s, wb_idx_s, qj_s, qk_s;
   logic                 qjv_s, qkv_s, issue_ok_s;
   logic [RR_IDX_W-1:0]  fi_base_s, fj_base_s, fk_base_s, wb_bit_s;
   logic [RR_W-1:0]      wb_mask_s, iss_row_mask_s, iss_set_s, reg_result_nxt_s;

   function automatic logic [FU_BITS-1:0] lowest_idx(input logic [NUM_FUS-1:0] vec);
      logic [FU_BITS-1:0] idx;
      idx = '0;
      for (int i = NUM_FUS - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = FU_BITS'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Read/write-back eligibility; WAR blocks a write while another FU still has to read Fi
   always_comb begin
      rd_elig_s = '0;
      wb_elig_s = '0;
      war_s     = '0;
      for (int f = 0; f < NUM_FUS; f++) begin
         for (int g = 0; g < NUM_FUS; g++) begin
            war_s[f] = war_s[f] | ((g != f) &&
                       (((fj_r[g] == fi_r[f]) && rj_r[g]) || ((fk_r[g] == fi_r[f]) && rk_r[g])));
         end
         rd_elig_s[f] = (state_r[f] == ST_ISSUED) && rj_r[f] && rk_r[f];
         wb_elig_s[f] = (state_r[f] == ST_WB_WAIT) && !war_s[f];
      end
   end

   // Grant selection and grant-port outputs (zeroed when no grant)
   always_comb begin
      rd_idx_s = lowest_idx(rd_elig_s);
      wb_idx_s = lowest_idx(wb_elig_s);
      rd_valid = |rd_elig_s;
      wb_valid = |wb_elig_s;
      rd_fu    = rd_valid ? rd_idx_s : '0;
      rd_fj    = rd_valid ? fj_r[rd_idx_s] : '0;
      rd_fk    = rd_valid ? fk_r[rd_idx_s] : '0;
      wb_fu    = wb_valid ? wb_idx_s : '0;
      wb_fi    = wb_valid ? fi_r[wb_idx_s] : '0;
      for (int f = 0; f < NUM_FUS; f++) begin
         fu_busy[f] = (state_r[f] != ST_IDLE);
      end
   end

   // Producer lookup for the incoming issue; a producer writing back this cycle counts as done
   always_comb begin
      issue_ok_s     = issue_valid && (state_r[issue_fu] == ST_IDLE);
      issue_onehot_s = NUM_FUS'(1) << issue_fu;
      wb_clr_s       = wb_valid ? (NUM_FUS'(1) << wb_idx_s) : '0;
      fi_base_s      = RR_IDX_W'(int'(issue_fi) * NUM_FUS);
      fj_base_s      = RR_IDX_W'(int'(issue_fj) * NUM_FUS);
      fk_base_s      = RR_IDX_W'(int'(issue_fk) * NUM_FUS);
      row_j_s        = reg_result_r[fj_base_s +: NUM_FUS] & ~wb_clr_s;
      row_k_s        = reg_result_r[fk_base_s +: NUM_FUS] & ~wb_clr_s;
      qjv_s          = (issue_fj != '0) && (|row_j_s);
      qkv_s          = (issue_fk != '0) && (|row_k_s);
      qj_s           = lowest_idx(row_j_s);
      qk_s           = lowest_idx(row_k_s);
   end

   // Next reg_result_fu: retire the write-back bit, then overwrite the issued row
   always_comb begin
      wb_bit_s         = RR_IDX_W'(int'(wb_fi) * NUM_FUS + int'(wb_fu));
      wb_mask_s        = wb_valid ? (RR_W'(1) << wb_bit_s) : '0;
      iss_row_mask_s   = (issue_ok_s && (issue_fi != '0)) ?
                         (RR_W'({NUM_FUS{1'b1}}) << fi_base_s) : '0;
      iss_set_s        = (issue_ok_s && (issue_fi != '0)) ?
                         (RR_W'(issue_onehot_s) << fi_base_s) : '0;
      reg_result_nxt_s = (reg_result_r & ~wb_mask_s & ~iss_row_mask_s) | iss_set_s;
   end

   // Per-FU record and state sequencing
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int f = 0; f < NUM_FUS; f++) begin
            state_r[f] <= ST_IDLE;
            fi_r[f]    <= '0;
            fj_r[f]    <= '0;
            fk_r[f]    <= '0;
            qj_r[f]    <= '0;
            qk_r[f]    <= '0;
         end
         qjv_r        <= '0;
         qkv_r        <= '0;
         rj_r         <= '0;
         rk_r         <= '0;
         reg_result_r <= '0;
         issue_err_r  <= 1'b0;
      end else begin
         reg_result_r <= reg_result_nxt_s;
         issue_err_r  <= issue_valid && !issue_ok_s;
         for (int f = 0; f < NUM_FUS; f++) begin
            case (state_r[f])
               ST_IDLE: begin
                  if (issue_ok_s && (issue_fu == FU_BITS'(f))) begin
                     state_r[f] <= ST_ISSUED;
                     fi_r[f]    <= issue_fi;
                     fj_r[f]    <= issue_fj;
                     fk_r[f]    <= issue_fk;
                     qj_r[f]    <= qj_s;
                     qk_r[f]    <= qk_s;
                     qjv_r[f]   <= qjv_s;
                     qkv_r[f]   <= qkv_s;
                     rj_r[f]    <= !qjv_s;
                     rk_r[f]    <= !qkv_s;
                  end
               end
               ST_ISSUED: begin
                  if (rd_valid && (rd_idx_s == FU_BITS'(f))) begin
                     state_r[f] <= ST_EXEC;
                     rj_r[f]    <= 1'b0;
                     rk_r[f]    <= 1'b0;
                  end else begin
                     if (wb_valid && qjv_r[f] && (qj_r[f] == wb_idx_s)) begin
                        rj_r[f]  <= 1'b1;
                        qjv_r[f] <= 1'b0;
                        qj_r[f]  <= '0;
                     end
                     if (wb_valid && qkv_r[f] && (qk_r[f] == wb_idx_s)) begin
                        rk_r[f]  <= 1'b1;
                        qkv_r[f] <= 1'b0;
                        qk_r[f]  <= '0;
                     end
                  end
               end
               ST_EXEC: begin
                  if (ex_done[f]) begin
                     state_r[f] <= ST_WB_WAIT;
                  end
               end
               ST_WB_WAIT: begin
                  if (wb_valid && (wb_idx_s == FU_BITS'(f))) begin
                     state_r[f] <= ST_IDLE;
                  end
               end
               default: state_r[f] <= ST_IDLE;
            endcase
         end
      end
   end

   assign reg_result_fu = reg_result_r;
   assign issue_err     = issue_err_r;

endmodule

// File: tb/tb_scoreboard_status_table.sv
// Randomized + directed bench for scoreboard_status_table against an
// array-based reference model of the scoreboard rules.
module tb_scoreboard_status_table;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         issue_valid;
   logic [1:0]   issue_fu;
   logic [4:0]   issue_fi, issue_fj, issue_fk;
   logic [3:0]   ex_done;
   logic [3:0]   fu_busy;
   logic [127:0] reg_result_fu;
   logic         rd_valid, wb_valid, issue_err;
   logic [1:0]   rd_fu, wb_fu;
   logic [4:0]   rd_fj, rd_fk, wb_fi;

   int n_checks = 0;
   int n_fail   = 0;

   localparam int M_IDLE = 0, M_ISSUED = 1, M_EXEC = 2, M_WB = 3;

   int m_st [4];
   int m_fi [4];
   int m_fj [4];
   int m_fk [4];
   int m_qj [4];
   int m_qk [4];
   bit m_rj [4];
   bit m_rk [4];
   int m_prod [32];
   bit m_err;

   scoreboard_status_table dut (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_fu(issue_fu),
      .issue_fi(issue_fi), .issue_fj(issue_fj), .issue_fk(issue_fk), .ex_done(ex_done),
      .fu_busy(fu_busy), .reg_result_fu(reg_result_fu), .rd_valid(rd_valid), .rd_fu(rd_fu),
      .rd_fj(rd_fj), .rd_fk(rd_fk), .wb_valid(wb_valid), .wb_fu(wb_fu), .wb_fi(wb_fi),
      .issue_err(issue_err)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      for (int f = 0; f < 4; f++) begin
         m_st[f] = M_IDLE; m_fi[f] = 0; m_fj[f] = 0; m_fk[f] = 0;
         m_qj[f] = -1; m_qk[f] = -1; m_rj[f] = 1'b0; m_rk[f] = 1'b0;
      end
      for (int r = 0; r < 32; r++) m_prod[r] = -1;
      m_err = 1'b0;
   endtask

   function automatic int m_rd_grant();
      for (int f = 0; f < 4; f++)
         if (m_st[f] == M_ISSUED && m_rj[f] && m_rk[f]) return f;
      return -1;
   endfunction

   function automatic int m_wb_grant();
      for (int f = 0; f < 4; f++) begin
         if (m_st[f] == M_WB) begin
            bit blocked = 1'b0;
            for (int g = 0; g < 4; g++)
               if (g != f && ((m_fj[g] == m_fi[f] && m_rj[g]) || (m_fk[g] == m_fi[f] && m_rk[g])))
                  blocked = 1'b1;
            if (!blocked) return f;
         end
      end
      return -1;
   endfunction

   function automatic logic [127:0] m_reg_result();
      logic [127:0] v = '0;
      for (int r = 0; r < 32; r++)
         if (m_prod[r] >= 0) v[r*4 + m_prod[r]] = 1'b1;
      return v;
   endfunction

   task automatic compare_all();
      int rg = m_rd_grant();
      int wg = m_wb_grant();
      logic [3:0] busy = '0;
      for (int f = 0; f < 4; f++) busy[f] = (m_st[f] != M_IDLE);
      chk_eq("fu_busy",       128'(fu_busy),       128'(busy));
      chk_eq("reg_result_fu", reg_result_fu,       m_reg_result());
      chk_eq("rd_valid",      128'(rd_valid),      128'(rg >= 0));
      chk_eq("rd_fu",         128'(rd_fu),         128'(rg >= 0 ? rg : 0));
      chk_eq("rd_fj",         128'(rd_fj),         128'(rg >= 0 ? m_fj[rg] : 0));
      chk_eq("rd_fk",         128'(rd_fk),         128'(rg >= 0 ? m_fk[rg] : 0));
      chk_eq("wb_valid",      128'(wb_valid),      128'(wg >= 0));
      chk_eq("wb_fu",         128'(wb_fu),         128'(wg >= 0 ? wg : 0));
      chk_eq("wb_fi",         128'(wb_fi),         128'(wg >= 0 ? m_fi[wg] : 0));
      chk_eq("issue_err",     128'(issue_err),     128'(m_err));
   endtask

   task automatic m_step(input bit rst, input bit iv, input int fu, input int fi,
                         input int fj, input int fk, input logic [3:0] ex);
      int rg, wg, pj, pk;
      bit accept;
      if (rst) begin
         m_reset();
         return;
      end
      rg = m_rd_grant();
      wg = m_wb_grant();
      pj = (fj == 0) ? -1 : m_prod[fj];
      pk = (fk == 0) ? -1 : m_prod[fk];
      if (wg >= 0 && pj == wg) pj = -1;
      if (wg >= 0 && pk == wg) pk = -1;
      accept = iv && (m_st[fu] == M_IDLE);
      m_err  = iv && !accept;
      for (int f = 0; f < 4; f++) begin
         if (f == rg) begin
            m_st[f] = M_EXEC; m_rj[f] = 1'b0; m_rk[f] = 1'b0;
         end else if (m_st[f] == M_ISSUED && wg >= 0) begin
            if (m_qj[f] == wg) begin m_rj[f] = 1'b1; m_qj[f] = -1; end
            if (m_qk[f] == wg) begin m_rk[f] = 1'b1; m_qk[f] = -1; end
         end else if (m_st[f] == M_EXEC && ex[f]) begin
            m_st[f] = M_WB;
         end else if (f == wg) begin
            m_st[f] = M_IDLE;
         end
      end
      if (wg >= 0 && m_prod[m_fi[wg]] == wg) m_prod[m_fi[wg]] = -1;
      if (accept) begin
         m_st[fu] = M_ISSUED;
         m_fi[fu] = fi; m_fj[fu] = fj; m_fk[fu] = fk;
         m_qj[fu] = pj; m_qk[fu] = pk;
         m_rj[fu] = (pj < 0); m_rk[fu] = (pk < 0);
         if (fi != 0) m_prod[fi] = fu;
      end
   endtask

   // Called at a falling edge: check, drive the next inputs, advance one cycle.
   task automatic tick(input bit rst, input bit iv, input int fu, input int fi,
                       input int fj, input int fk, input logic [3:0] ex);
      compare_all();
      rst_n       = !rst;
      issue_valid = iv;
      issue_fu    = 2'(fu);
      issue_fi    = 5'(fi);
      issue_fj    = 5'(fj);
      issue_fk    = 5'(fk);
      ex_done     = ex;
      m_step(rst, iv, fu, fi, fj, fk, ex);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic [3:0] ex);
      tick(1'b0, 1'b0, 0, 0, 0, 0, ex);
   endtask

   initial begin
      rst_n = 1'b0; issue_valid = 1'b0; issue_fu = 2'd0;
      issue_fi = 5'd0; issue_fj = 5'd0; issue_fk = 5'd0; ex_done = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      m_reset();

      // Basic flow: FU0 r3 <- r1,r2
      tick(1'b0, 1'b1, 0, 3, 1, 2, 4'd0);
      chk_eq("basic_busy",   128'(fu_busy), 128'(4'b0001));
      chk_eq("basic_rr12",   128'(reg_result_fu[12]), 128'(1'b1));
      chk_eq("basic_rd",     128'({rd_valid, rd_fu, rd_fj, rd_fk}), 128'({1'b1, 2'd0, 5'd1, 5'd2}));
      idle(4'd0);
      idle(4'b0001);
      chk_eq("basic_wb",     128'({wb_valid, wb_fi}), 128'({1'b1, 5'd3}));
      idle(4'd0);
      chk_eq("basic_idle",   128'(fu_busy), 128'(4'b0000));

      // RAW: FU2 r5 <- r1,r2 then FU0 r6 <- r5,r1
      tick(1'b0, 1'b1, 2, 5, 1, 2, 4'd0);
      tick(1'b0, 1'b1, 0, 6, 5, 1, 4'd0);
      chk_eq("raw_wait",     128'(rd_valid), 128'(1'b0));
      idle(4'b0100);
      chk_eq("raw_wait_wb",  128'({rd_valid, wb_valid, wb_fu}), 128'({1'b0, 1'b1, 2'd2}));
      idle(4'd0);
      chk_eq("raw_read",     128'({rd_valid, rd_fu}), 128'({1'b1, 2'd0}));
      idle(4'd0);
      idle(4'b0001);
      idle(4'd0);

      // WAR: FU3 r8, FU2 r7 <- r8,r9, FU0 r9 <- r1,r1
      tick(1'b1, 1'b0, 0, 0, 0, 0, 4'd0);
      tick(1'b0, 1'b1, 3, 8, 1, 1, 4'd0);
      tick(1'b0, 1'b1, 2, 7, 8, 9, 4'd0);
      tick(1'b0, 1'b1, 0, 9, 1, 1, 4'd0);
      idle(4'd0);
      idle(4'b0001);
      chk_eq("war_block",    128'(wb_valid), 128'(1'b0));
      idle(4'b1000);
      chk_eq("war_fu3_wb",   128'({wb_valid, wb_fu}), 128'({1'b1, 2'd3}));
      idle(4'd0);
      chk_eq("war_fu2_rd",   128'({rd_valid, rd_fu, wb_valid}), 128'({1'b1, 2'd2, 1'b0}));
      idle(4'd0);
      chk_eq("war_fu0_wb",   128'({wb_valid, wb_fu, wb_fi}), 128'({1'b1, 2'd0, 5'd9}));

      // Simultaneous read eligibility of FU0 and FU1
      tick(1'b1, 1'b0, 0, 0, 0, 0, 4'd0);
      tick(1'b0, 1'b1, 3, 5, 1, 1, 4'd0);
      tick(1'b0, 1'b1, 0, 6, 5, 1, 4'd0);
      tick(1'b0, 1'b1, 1, 7, 5, 2, 4'd0);
      idle(4'b1000);
      idle(4'd0);
      chk_eq("prio_fu0",     128'({rd_valid, rd_fu}), 128'({1'b1, 2'd0}));
      idle(4'd0);
      chk_eq("prio_fu1",     128'({rd_valid, rd_fu}), 128'({1'b1, 2'd1}));

      // Busy issue, ignored ex_done, reset with three FUs busy, r0 destination
      tick(1'b1, 1'b0, 0, 0, 0, 0, 4'd0);
      tick(1'b0, 1'b1, 2, 6, 1, 1, 4'd0);
      tick(1'b0, 1'b1, 1, 4, 6, 1, 4'd0);
      tick(1'b0, 1'b1, 1, 10, 2, 3, 4'd0);
      chk_eq("busy_err",     128'(issue_err), 128'(1'b1));
      chk_eq("busy_row10",   128'(reg_result_fu[43:40]), 128'(4'b0000));
      tick(1'b0, 1'b1, 3, 11, 1, 2, 4'b0010);
      chk_eq("busy_err_end", 128'(issue_err), 128'(1'b0));
      chk_eq("busy_three",   128'(fu_busy), 128'(4'b1110));
      tick(1'b1, 1'b1, 0, 5, 1, 1, 4'b1111);
      chk_eq("rst_outputs",  128'({fu_busy, rd_valid, wb_valid, issue_err}), 128'(7'd0));
      chk_eq("rst_rr",       reg_result_fu, 128'(0));
      tick(1'b0, 1'b1, 0, 0, 1, 2, 4'd0);
      chk_eq("r0_row",       reg_result_fu, 128'(0));
      chk_eq("r0_busy",      128'(fu_busy), 128'(4'b0001));

      // Random traffic with small register range to force hazards
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] ex;
         for (int i = 0; i < 4; i++) ex[i] = ($urandom_range(0, 2) == 0);
         tick($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), ex);
      end
      compare_all();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
